shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
- Multi-cycle, registered shift unit. Iterative counterpart to the combinational left/right shifters in the ALU.
- Latches operand A, shift count B, direction and fill bit on a start handshake.
- Shifts one position per clock, then presents the result and the same C/N/V flags plus Z, with a one-cycle done pulse.
- Used in the datapath where a registered, low-area shifter is needed instead of the combinational one.

Parameters:
- bits, 4, operand and result width; also the width of the shift count input.

Ports:
- SS_clk  in  1  clock; all state changes on the rising edge.
- SS_rst_n  in  1  reset, asynchronous, active-low.
- SS_start  in  1  request. Sampled only while SS_ready=1.
- SS_dir  in  1  direction: 0 = left (toward MSB), 1 = right (toward LSB).
- SS_Fin  in  1  fill bit shifted into the vacated end each step.
- SS_inA  in  bits  operand.
- SS_inB  in  bits  shift count (unsigned).
- SS_ready  out  1  high in IDLE only.
- SS_done  out  1  one-cycle pulse when the result is valid.
- SS_out  out  bits  result, held until the next completed operation.
- SS_C  out  1  carry: last bit shifted out.
- SS_N  out  1  SS_out[bits-1].
- SS_Z  out  1  1 when SS_out == 0.
- SS_V  out  1  always 0.

Behaviour:
- Reset (async, SS_rst_n=0): state=IDLE, SS_ready=1, SS_done=0, SS_out=0, SS_C=0, SS_N=0, SS_Z=1, SS_V=0.
  - Internal work register, carry and counter are cleared.
  - Reset mid-operation aborts the operation. No done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE, SS_start=1 at an edge:
  - Latch A into the work register; latch dir and Fin; clear the internal carry.
  - Load k = min(SS_inB, bits+1), using a counter at least clog2(bits+2) bits wide, so k saturates with no wrap.
  - If k==0, go to DONE; else go to SHIFT.
- SHIFT, each edge:
  - Left: carry <= work[bits-1]; work <= {work[bits-2:0], Fin}.
  - Right: carry <= work[0]; work <= {Fin, work[bits-1:1]}.
  - Decrement k. When k reaches 0, go to DONE.
- DONE, for one cycle:
  - SS_done=1.
  - SS_out, SS_C, SS_N, SS_Z were registered from work/carry on the transition into DONE.
  - Next edge returns to IDLE.
- SS_ready=1 only in IDLE. SS_start in SHIFT or DONE is ignored, with no queuing. New operands take effect only at the next IDLE start.
- Latency: SS_done goes high k+1 rising edges after the start edge.
  - Minimum 1 edge (B=0); maximum bits+2 edges.
- Result equivalence: outputs equal the combinational shifter's for the same A, B, Fin, dir:
  - B=0: out=A, C=0.
  - 1<=B<=bits: C = A[bits-B] (left) or A[B-1] (right).
  - B>bits: out = all Fin, C = Fin.
- Outputs hold their last values between operations. SS_inA/SS_inB changes while busy have no effect.
- Back-to-back: start is accepted on the first IDLE cycle after DONE, so there is a 1-cycle gap between operations.

Test Plan (bits=4):
- Left, A=1011, B=1, Fin=0 -> done after 2 edges; out=0110, C=1, N=0, Z=0, V=0.
- Right, A=1011, B=2, Fin=1 -> done after 3 edges; out=1110, C=1, N=1, Z=0.
- B=0, A=1001, either dir -> done after 1 edge; out=1001, C=0, N=1.
- Saturation and zero result:
  - Left, A=0001, B=4, Fin=0 -> out=0000, C=1, Z=1, 5 edges.
  - Left, A=0000, B=9, Fin=1 -> k=5, done after 6 edges; out=1111, C=1, N=1.
- Start pulsed during SHIFT with different A/B -> ignored; the first result is unaffected; ready stays 0 until IDLE.
- Assert SS_rst_n=0 mid-SHIFT, asynchronously between edges -> outputs immediately return to their reset values, no done pulse; the next start works normally.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: iterative, registered barrel-shift replacement.
// Shifts the latched operand one position per clock, then presents the
// result with C/N/Z/V flags and a one-cycle done pulse. Outputs hold their
// values between operations.
module shift_seq #(
    parameter int unsigned bits = 4
) (
    input  logic            SS_clk,
    input  logic            SS_rst_n,
    input  logic            SS_start,
    input  logic            SS_dir,
    input  logic            SS_Fin,
    input  logic [bits-1:0] SS_inA,
    input  logic [bits-1:0] SS_inB,
    output logic            SS_ready,
    output logic            SS_done,
    output logic [bits-1:0] SS_out,
    output logic            SS_C,
    output logic            SS_N,
    output logic            SS_Z,
    output logic            SS_V
);

    // The counter must hold bits+1 so that large counts saturate instead of wrapping.
    localparam int unsigned KW = $clog2(bits + 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [bits-1:0] work;
    logic            carry;
    logic            dir_q;
    logic            fill_q;
    logic [KW-1:0]   count;

    logic [KW-1:0]   k_load;
    logic [bits-1:0] shift_work;
    logic            shift_carry;
    logic            last_step;

    logic [bits-1:0] out_q;
    logic            c_q;
    logic            z_q;

    // Saturate the requested count at bits+1; every count beyond that gives all-fill.
    always_comb begin
        k_load = KW'(SS_inB);
        if (32'(SS_inB) > (bits + 1)) begin
            k_load = KW'(bits + 1);
        end
    end

    // One-position shift of the work register in the latched direction.
    always_comb begin
        shift_work  = work;
        shift_carry = carry;
        if (dir_q) begin
            shift_carry = work[0];
            shift_work  = {fill_q, work[bits-1:1]};
        end else begin
            shift_carry = work[bits-1];
            shift_work  = {work[bits-2:0], fill_q};
        end
    end

    assign last_step = (count == KW'(1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge SS_clk or negedge SS_rst_n) begin
        if (!SS_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: zero-count requests skip straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (SS_start) begin
                    state_next = (k_load == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch on start, shift while counting, capture results entering DONE.
    always_ff @(posedge SS_clk or negedge SS_rst_n) begin
        if (!SS_rst_n) begin
            work   <= '0;
            carry  <= 1'b0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
            count  <= '0;
            out_q  <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (SS_start) begin
                        work   <= SS_inA;
                        carry  <= 1'b0;
                        dir_q  <= SS_dir;
                        fill_q <= SS_Fin;
                        count  <= k_load;
                        if (k_load == '0) begin
                            out_q <= SS_inA;
                            c_q   <= 1'b0;
                            z_q   <= (SS_inA == '0);
                        end
                    end
                end
                SHIFT: begin
                    work  <= shift_work;
                    carry <= shift_carry;
                    count <= count - KW'(1);
                    if (last_step) begin
                        out_q <= shift_work;
                        c_q   <= shift_carry;
                        z_q   <= (shift_work == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SS_ready = (state == IDLE);
    assign SS_done  = (state == DONE);
    assign SS_out   = out_q;
    assign SS_C     = c_q;
    assign SS_N     = out_q[bits-1];
    assign SS_Z     = z_q;
    assign SS_V     = 1'b0;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard bench for shift_seq with bits=4.
// Expected results are pushed when a request is driven and popped when
// the DUT pulses done; latency is measured in rising edges.
module tb_shift_seq;

    localparam int BITS = 4;

    logic            SS_clk;
    logic            SS_rst_n;
    logic            SS_start;
    logic            SS_dir;
    logic            SS_Fin;
    logic [BITS-1:0] SS_inA;
    logic [BITS-1:0] SS_inB;
    logic            SS_ready;
    logic            SS_done;
    logic [BITS-1:0] SS_out;
    logic            SS_C;
    logic            SS_N;
    logic            SS_Z;
    logic            SS_V;

    typedef struct {
        logic [BITS-1:0] out;
        logic            c;
        logic            n;
        logic            z;
        int              lat;
        int              start_cycle;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t last_exp;
    bit   have_last;
    bit   prev_done;

    int tests_run;
    int tests_failed;
    int cycle;

    shift_seq #(.bits(BITS)) dut (
        .SS_clk  (SS_clk),
        .SS_rst_n(SS_rst_n),
        .SS_start(SS_start),
        .SS_dir  (SS_dir),
        .SS_Fin  (SS_Fin),
        .SS_inA  (SS_inA),
        .SS_inB  (SS_inB),
        .SS_ready(SS_ready),
        .SS_done (SS_done),
        .SS_out  (SS_out),
        .SS_C    (SS_C),
        .SS_N    (SS_N),
        .SS_Z    (SS_Z),
        .SS_V    (SS_V)
    );

    // Free-running clock, period 10.
    initial begin
        SS_clk = 1'b0;
        forever #5 SS_clk = ~SS_clk;
    end

    // Rising-edge counter used for latency measurement.
    initial cycle = 0;
    always @(posedge SS_clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model written from the combinational shifter's definition.
    function automatic exp_t model(input bit dir, input bit fin,
                                   input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        exp_t e;
        int   n;
        int   idx;
        n = int'(b);
        e.out = '0;
        e.c   = 1'b0;
        if (n == 0) begin
            e.out = a;
            e.c   = 1'b0;
            e.lat = 1;
        end else if (n > BITS) begin
            e.out = {BITS{fin}};
            e.c   = fin;
            e.lat = BITS + 2;
        end else begin
            for (int i = 0; i < BITS; i++) begin
                idx = dir ? (i + n) : (i - n);
                e.out[i] = (idx >= 0 && idx < BITS) ? a[idx] : fin;
            end
            e.c   = dir ? a[n-1] : a[BITS-n];
            e.lat = n + 1;
        end
        e.n = e.out[BITS-1];
        e.z = (e.out == '0);
        e.start_cycle = 0;
        return e;
    endfunction

    // Wait (bounded) for ready, drive one start cycle and push the expectation.
    task automatic applyStimulus(input bit dir, input bit fin,
                                 input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge SS_clk);
        while (!SS_ready && waited < 50) begin
            @(negedge SS_clk);
            waited++;
        end
        if (!SS_ready) begin
            checkOutput("ready_timeout", 32'(SS_ready), 32'd1);
        end else begin
            SS_dir   = dir;
            SS_Fin   = fin;
            SS_inA   = a;
            SS_inB   = b;
            SS_start = 1'b1;
            e = model(dir, fin, a, b);
            e.start_cycle = cycle + 1;
            exp_q.push_back(e);
            @(negedge SS_clk);
            SS_start = 1'b0;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge SS_clk);
            waited++;
        end
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: compare on every done pulse, and check the result holds afterwards.
    always @(negedge SS_clk) begin
        if (SS_rst_n) begin
            if (SS_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'(SS_done), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("out", 32'(SS_out), 32'(cur.out));
                    checkOutput("C", 32'(SS_C), 32'(cur.c));
                    checkOutput("N", 32'(SS_N), 32'(cur.n));
                    checkOutput("Z", 32'(SS_Z), 32'(cur.z));
                    checkOutput("V", 32'(SS_V), 32'd0);
                    checkOutput("ready_in_done", 32'(SS_ready), 32'd0);
                    checkOutput("latency", 32'(cycle - cur.start_cycle + 1), 32'(cur.lat));
                    last_exp  = cur;
                    have_last = 1'b1;
                end
            end else if (prev_done && have_last) begin
                checkOutput("hold_out", 32'(SS_out), 32'(last_exp.out));
                checkOutput("hold_C", 32'(SS_C), 32'(last_exp.c));
            end
            prev_done = SS_done;
        end else begin
            prev_done = 1'b0;
            have_last = 1'b0;
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out"},   32'(SS_out),   32'd0);
        checkOutput({tag, "_C"},     32'(SS_C),     32'd0);
        checkOutput({tag, "_N"},     32'(SS_N),     32'd0);
        checkOutput({tag, "_Z"},     32'(SS_Z),     32'd1);
        checkOutput({tag, "_V"},     32'(SS_V),     32'd0);
        checkOutput({tag, "_ready"}, 32'(SS_ready), 32'd1);
        checkOutput({tag, "_done"},  32'(SS_done),  32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        have_last    = 1'b0;
        prev_done    = 1'b0;
        SS_rst_n     = 1'b0;
        SS_start     = 1'b0;
        SS_dir       = 1'b0;
        SS_Fin       = 1'b0;
        SS_inA       = '0;
        SS_inB       = '0;

        repeat (2) @(negedge SS_clk);
        checkResetValues("reset");
        SS_rst_n = 1'b1;

        // Directed cases from the test plan.
        applyStimulus(1'b0, 1'b0, 4'b1011, 4'd1);
        applyStimulus(1'b1, 1'b1, 4'b1011, 4'd2);
        applyStimulus(1'b0, 1'b0, 4'b1001, 4'd0);
        applyStimulus(1'b1, 1'b1, 4'b1001, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'b0001, 4'd4);
        applyStimulus(1'b0, 1'b1, 4'b0000, 4'd9);
        applyStimulus(1'b1, 1'b0, 4'b1000, 4'd4);
        applyStimulus(1'b1, 1'b0, 4'b0110, 4'd15);
        drain();

        // Start pulsed during SHIFT with different operands is ignored.
        applyStimulus(1'b0, 1'b0, 4'b1011, 4'd3);
        checkOutput("ready_busy", 32'(SS_ready), 32'd0);
        SS_start = 1'b1;
        SS_inA   = 4'b0000;
        SS_inB   = 4'd0;
        SS_dir   = 1'b1;
        SS_Fin   = 1'b1;
        @(negedge SS_clk);
        checkOutput("ready_busy2", 32'(SS_ready), 32'd0);
        @(negedge SS_clk);
        SS_start = 1'b0;
        drain();

        // Asynchronous reset mid-SHIFT aborts without a done pulse.
        applyStimulus(1'b0, 1'b1, 4'b0101, 4'd4);
        @(negedge SS_clk);
        #2;
        SS_rst_n = 1'b0;
        #1;
        checkResetValues("abort");
        exp_q.delete();
        @(negedge SS_clk);
        SS_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b1101, 4'd1);
        drain();

        // Random back-to-back operations.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        drain();

        repeat (3) @(negedge SS_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
